// File: rtl/calc_entry_engine.sv
// rtl/calc_entry_engine.sv - keypad-to-ALU calculator entry controller
// Accumulates hex operands, captures an ALU command, registers and shows the result.
module calc_entry_engine #(
  parameter int N_DIGITS = 4,
  parameter bit CHAIN_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            val,
  input  logic                  enter_button,
  output logic [4*N_DIGITS-1:0] op1,
  output logic [4*N_DIGITS-1:0] op2,
  output logic [2:0]            op,
  output logic [4*N_DIGITS-1:0] output_number,
  output logic                  overflow,
  output logic                  entry_full,
  output logic [1:0]            state_o
);
  localparam int W  = 4 * N_DIGITS;
  localparam int CW = $clog2(N_DIGITS + 1);

  localparam logic [4:0] K_CE    = 5'h10;
  localparam logic [4:0] K_BKSP  = 5'h11;
  localparam logic [4:0] K_AC    = 5'h12;
  localparam logic [4:0] K_ENTER = 5'h13;
  localparam logic [4:0] K_CHAIN = 5'h14;

  typedef enum logic [1:0] {
    S_OP1  = 2'd0,
    S_OP2  = 2'd1,
    S_ALU  = 2'd2,
    S_SHOW = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   entry_q, entry_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   op1_q, op1_d;
  logic [W-1:0]   op2_q, op2_d;
  logic [2:0]     op_q, op_d;
  logic [2:0]     pend_q, pend_d;
  logic [W-1:0]   result_q, result_d;
  logic           ovf_q, ovf_d;

  logic [W:0]     sum_w, diff_w;
  logic [2*W-1:0] prod_w;
  logic [W-1:0]   alu_res;
  logic           alu_ovf;

  // ALU always evaluates the pending command so ENTER can register it directly.
  always_comb begin
    sum_w   = {1'b0, op1_q} + {1'b0, op2_q};
    diff_w  = {1'b0, op1_q} - {1'b0, op2_q};
    prod_w  = {{W{1'b0}}, op1_q} * {{W{1'b0}}, op2_q};
    alu_res = '0;
    alu_ovf = 1'b0;
    case (pend_q)
      3'd0: begin alu_res = sum_w[W-1:0];  alu_ovf = sum_w[W];  end
      3'd1: begin alu_res = diff_w[W-1:0]; alu_ovf = diff_w[W]; end
      3'd2: alu_res = op1_q & op2_q;
      3'd3: alu_res = op1_q | op2_q;
      3'd4: alu_res = op1_q ^ op2_q;
      3'd5: begin alu_res = prod_w[W-1:0]; alu_ovf = |prod_w[2*W-1:W]; end
      default: begin alu_res = '0; alu_ovf = 1'b0; end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    cnt_d    = cnt_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    op_d     = op_q;
    pend_d   = pend_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    if (enter_button) begin
      if (val == K_AC) begin
        state_d  = S_OP1;
        entry_d  = '0;
        cnt_d    = '0;
        op1_d    = '0;
        op2_d    = '0;
        op_d     = '0;
        pend_d   = '0;
        result_d = '0;
        ovf_d    = 1'b0;
      end else begin
        case (state_q)
          S_OP1, S_OP2: begin
            if (!val[4]) begin
              if (cnt_q < CW'(N_DIGITS)) begin
                entry_d = (entry_q << 4) | W'(val[3:0]);
                cnt_d   = cnt_q + CW'(1);
              end
            end else if (val == K_BKSP) begin
              if (cnt_q != '0) begin
                entry_d = entry_q >> 4;
                cnt_d   = cnt_q - CW'(1);
              end
            end else if (val == K_CE) begin
              entry_d = '0;
              cnt_d   = '0;
            end else if (val == K_ENTER) begin
              if (state_q == S_OP1) begin
                op1_d   = entry_q;
                state_d = S_OP2;
              end else begin
                op2_d   = entry_q;
                state_d = S_ALU;
              end
              entry_d = '0;
              cnt_d   = '0;
            end
          end
          S_ALU: begin
            if (!val[4]) begin
              if (!val[3]) pend_d = val[2:0];
            end else if (val == K_CE || val == K_BKSP) begin
              pend_d = '0;
            end else if (val == K_ENTER) begin
              op_d     = pend_q;
              result_d = alu_res;
              ovf_d    = alu_ovf;
              state_d  = S_SHOW;
            end
          end
          default: begin
            if (val == K_ENTER) begin
              state_d = S_OP1;
              ovf_d   = 1'b0;
              entry_d = '0;
              cnt_d   = '0;
            end else if (CHAIN_EN && val == K_CHAIN) begin
              op1_d   = result_q;
              state_d = S_OP2;
              ovf_d   = 1'b0;
              entry_d = '0;
              cnt_d   = '0;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_OP1;
      entry_q  <= '0;
      cnt_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      op_q     <= '0;
      pend_q   <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      entry_q  <= entry_d;
      cnt_q    <= cnt_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      op_q     <= op_d;
      pend_q   <= pend_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    case (state_q)
      S_OP1, S_OP2: output_number = entry_q;
      S_ALU:        output_number = W'(pend_q);
      default:      output_number = result_q;
    endcase
  end

  assign op1        = op1_q;
  assign op2        = op2_q;
  assign op         = op_q;
  assign overflow   = ovf_q;
  assign entry_full = (cnt_q == CW'(N_DIGITS));
  assign state_o    = state_q;
endmodule
